// File: rtl/instr_decode_queue_if.sv
// Handshake bundle between fetch, the decode queue and register-read.
// The master drives instructions in and consumes decoded entries; the slave is the queue.
interface instr_decode_queue_if #(
  parameter int unsigned XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [5:0]      out_opcode;
  logic [4:0]      out_rc;
  logic [4:0]      out_ra;
  logic [4:0]      out_rb;
  logic [XLEN-1:0] out_lit;
  logic            out_use_lit;
  logic            out_is_mem;
  logic            out_is_branch;
  logic            out_we;
  logic [3:0]      out_alu_op;
  logic            out_illop;

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_opcode, out_rc, out_ra, out_rb, out_lit,
           out_use_lit, out_is_mem, out_is_branch, out_we, out_alu_op, out_illop
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_opcode, out_rc, out_ra, out_rb, out_lit,
           out_use_lit, out_is_mem, out_is_branch, out_we, out_alu_op, out_illop
  );
endinterface

// File: rtl/instr_decode_queue.sv
// Beta decode stage: combinational decode into a BUF_DEPTH-entry FIFO with a registered head.
// Optional macro DECODE_ILLOP_EN flags illegal opcodes on out_illop (tied 0 otherwise).
module instr_decode_queue #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned BUF_DEPTH = 2
) (
  input logic                 clk,
  input logic                 reset,
  input logic                 flush,
  instr_decode_queue_if.slave bus
);
  localparam int unsigned PtrW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [5:0]      opcode;
    logic [4:0]      rc;
    logic [4:0]      ra;
    logic [4:0]      rb;
    logic [XLEN-1:0] lit;
    logic            use_lit;
    logic            is_mem;
    logic            is_branch;
    logic            we;
    logic [3:0]      alu_op;
    logic            illop;
  } dec_t;

  dec_t            dec;
  dec_t            mem_q [BUF_DEPTH];
  dec_t            head_q, head_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [5:0]      op;
  logic            is_ld, is_st, is_ldr, is_jmp, is_beq, is_bne, is_alu, legal;
  logic            full, push, pop, load_head;

  // Decode
  always_comb begin
    op     = bus.in_instr[31:26];
    is_ld  = (op == 6'b011000);
    is_st  = (op == 6'b011001);
    is_jmp = (op == 6'b011011);
    is_beq = (op == 6'b011100);
    is_bne = (op == 6'b011101);
    is_ldr = (op == 6'b011111);
    is_alu = op[5] && (op[3:0] != 4'b0111) && (op[3:0] != 4'b1111);
    legal  = is_alu || is_ld || is_st || is_ldr || is_jmp || is_beq || is_bne;

    dec           = '0;
    dec.pc        = bus.in_pc;
    dec.opcode    = op;
    dec.rc        = bus.in_instr[25:21];
    dec.ra        = bus.in_instr[20:16];
    dec.rb        = bus.in_instr[15:11];
    dec.lit       = {{(XLEN-16){bus.in_instr[15]}}, bus.in_instr[15:0]};
    dec.is_mem    = is_ld || is_st || is_ldr;
    dec.is_branch = is_jmp || is_beq || is_bne;
    dec.use_lit   = (op[5:4] == 2'b11) || dec.is_mem;
    dec.we        = legal && !is_st;
    dec.alu_op    = is_alu ? op[3:0] : 4'b0000;
`ifdef DECODE_ILLOP_EN
    dec.illop     = !legal;
`else
    dec.illop     = 1'b0;
`endif
  end

  // FIFO control; full blocks push even if a pop happens in the same cycle
  always_comb begin
    full     = (count_q == CntW'(BUF_DEPTH));
    push     = bus.in_valid && !full && !flush;
    pop      = (count_q != '0) && bus.out_ready && !flush;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      if (push && !pop)      count_d = count_q + CntW'(1);
      else if (pop && !push) count_d = count_q - CntW'(1);
    end
  end

  // The new head may be the entry being written this cycle, so bypass it
  always_comb begin
    head_d    = (push && (wr_ptr_q == rd_ptr_d)) ? dec : mem_q[rd_ptr_d];
    load_head = !flush && (count_d != '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      if (push)      mem_q[wr_ptr_q] <= dec;
      if (load_head) head_q          <= head_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign bus.in_ready      = (count_q != CntW'(BUF_DEPTH));
  assign bus.out_valid     = (count_q != '0);
  assign bus.out_pc        = head_q.pc;
  assign bus.out_opcode    = head_q.opcode;
  assign bus.out_rc        = head_q.rc;
  assign bus.out_ra        = head_q.ra;
  assign bus.out_rb        = head_q.rb;
  assign bus.out_lit       = head_q.lit;
  assign bus.out_use_lit   = head_q.use_lit;
  assign bus.out_is_mem    = head_q.is_mem;
  assign bus.out_is_branch = head_q.is_branch;
  assign bus.out_we        = head_q.we;
  assign bus.out_alu_op    = head_q.alu_op;
  assign bus.out_illop     = head_q.illop;
endmodule

// File: tb/tb_instr_decode_queue.sv
// Scoreboard bench for instr_decode_queue: an independent decode model feeds an expected queue
// that is popped whenever the DUT hands out an entry.
module tb_instr_decode_queue;
  logic clk = 1'b0;
  logic reset;
  logic flush;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  logic [127:0] sb_q[$];

  instr_decode_queue_if #(.XLEN(32)) bus ();

  instr_decode_queue #(
    .XLEN     (32),
    .BUF_DEPTH(2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .flush(flush),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  // Reference decode, packed {pc, op, rc, ra, rb, lit, use_lit, mem, br, we, alu_op, illop}
  function automatic logic [127:0] model(input logic [31:0] ins, input logic [31:0] pc);
    logic [5:0]  o;
    logic        mem, br, alu, ok, ul, we, il;
    logic [3:0]  aop;
    logic [31:0] lit;
    o   = ins[31:26];
    mem = (o == 6'o30) || (o == 6'o31) || (o == 6'o37);
    br  = (o == 6'o33) || (o == 6'o34) || (o == 6'o35);
    alu = o[5] && (o[2:0] != 3'b111);
    ok  = mem || br || alu;
    ul  = (o[5] && o[4]) || mem;
    we  = ok && (o != 6'o31);
    aop = alu ? o[3:0] : 4'd0;
    lit = ins[15] ? {16'hFFFF, ins[15:0]} : {16'h0000, ins[15:0]};
`ifdef DECODE_ILLOP_EN
    il  = !ok;
`else
    il  = 1'b0;
`endif
    return {34'd0, pc, o, ins[25:21], ins[20:16], ins[15:11], lit, ul, mem, br, we, aop, il};
  endfunction

  function automatic logic [127:0] observed();
    return {34'd0, bus.out_pc, bus.out_opcode, bus.out_rc, bus.out_ra, bus.out_rb, bus.out_lit,
            bus.out_use_lit, bus.out_is_mem, bus.out_is_branch, bus.out_we, bus.out_alu_op,
            bus.out_illop};
  endfunction

  // Scoreboard: compare on handshake, record accepted inputs
  always @(negedge clk) begin
    if (reset || flush) begin
      sb_q.delete();
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        if (sb_q.size() == 0) check("sb_underflow", 1'b1, 1'b0);
        else check("sb_entry", observed(), sb_q.pop_front());
      end
      if (bus.in_valid && bus.in_ready) sb_q.push_back(model(bus.in_instr, bus.in_pc));
    end
  end

  task automatic send(input logic [31:0] ins, input logic [31:0] pc);
    logic acc;
    int   n = 0;
    bus.in_valid = 1'b1;
    bus.in_instr = ins;
    bus.in_pc    = pc;
    do begin
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 50);
    if (!acc) check("send_timeout", 1'b0, 1'b1);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    bus.out_ready = 1'b1;
    while ((sb_q.size() != 0 || bus.out_valid) && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(tag, {sb_q.size() != 0, bus.out_valid}, 2'b00);
  endtask

  logic [5:0] ops [16] = '{6'o30, 6'o31, 6'o33, 6'o34, 6'o35, 6'o37, 6'o40, 6'o46, 6'o50,
                           6'o60, 6'o66, 6'o76, 6'o00, 6'o27, 6'o47, 6'o77};

  initial begin
    int c0;
    logic [31:0] w;
    reset         = 1'b1;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.in_pc     = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_in_ready", bus.in_ready, 1'b1);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_outputs", observed(), '0);
    @(posedge clk);
    #1;
    check("idle_out_valid", bus.out_valid, 1'b0);

    // ADDC r3,r1,-1 with one-cycle latency
    bus.out_ready = 1'b1;
    send(32'hC061FFFF, 32'h0000_0100);
    check("addc_valid", bus.out_valid, 1'b1);
    check("addc_rc_ra", {bus.out_rc, bus.out_ra}, {5'd3, 5'd1});
    check("addc_lit", bus.out_lit, 32'hFFFF_FFFF);
    check("addc_ctl", {bus.out_use_lit, bus.out_alu_op, bus.out_we}, {1'b1, 4'b0000, 1'b1});
    drain("addc_drain");

    // Backpressure: two accepted, third held until the consumer resumes
    bus.out_ready = 1'b0;
    fork
      begin
        send(32'h6043_0004, 32'h200);
        send(32'h8085_1000, 32'h204);
        send(32'hF0C7_8001, 32'h208);
      end
      begin
        repeat (4) @(posedge clk);
        #2;
        check("full_in_ready", bus.in_ready, 1'b0);
        check("full_out_valid", bus.out_valid, 1'b1);
        check("full_head_pc", bus.out_pc, 32'h200);
        bus.out_ready = 1'b1;
      end
    join
    drain("bp_drain");

    // Streaming, one word per cycle
    bus.out_ready = 1'b1;
    c0 = cyc;
    for (int i = 0; i < 100; i++) begin
      w = $urandom;
      w[31:26] = ops[$urandom_range(0, 15)];
      send(w, 32'h1000 + 4 * i);
    end
    check("stream_cycles", cyc - c0, 100);
    drain("stream_drain");

    // Flush while full, with a push attempt
    bus.out_ready = 1'b0;
    send(32'h8000_0000, 32'h300);
    send(32'h8000_0001, 32'h304);
    flush        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_instr = 32'h8000_0002;
    @(posedge clk);
    #1;
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    check("flush_full_valid", bus.out_valid, 1'b0);
    check("flush_full_ready", bus.in_ready, 1'b1);

    // Flush with one entry; the push in the flush cycle must be dropped
    send(32'h8000_0003, 32'h310);
    flush        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_instr = 32'h8000_0004;
    @(posedge clk);
    #1;
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("flush_push_dropped", bus.out_valid, 1'b0);

    // Illegal opcode 000000
    send(32'h0022_1234, 32'h400);
`ifdef DECODE_ILLOP_EN
    check("illop_flag", bus.out_illop, 1'b1);
`else
    check("illop_flag", bus.out_illop, 1'b0);
`endif
    check("illop_ctl", {bus.out_we, bus.out_is_mem, bus.out_is_branch}, 3'b000);
    drain("illop_drain");

    // Reset mid-stream zeroes outputs
    bus.out_ready = 1'b0;
    send(32'hC3FF_8000, 32'h500);
    check("pre_rst_lit", bus.out_lit, 32'hFFFF_8000);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("mid_rst_valid", {bus.out_valid, bus.in_ready}, 2'b01);
    check("mid_rst_outputs", observed(), '0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
